lfsr_scrambler: RTL and testbench

LFSR_SCRAMBLER -- requirements
Module: lfsr_scrambler

---
 rtl/lfsr_pkg.sv | 16 +
 rtl/lfsr_core.sv | 80 ++++++++
 rtl/lfsr_scrambler.sv | 76 +++++++
 tb/tb_lfsr_scrambler.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared mode encoding and default LFSR constants for the scrambler slice.
package lfsr_pkg;

  typedef enum logic [1:0] {
    GEN  = 2'b00,
    SCR  = 2'b01,
    DSCR = 2'b10,
    RSVD = 2'b11
  } mode_e;

  localparam int          DEFAULT_WIDTH    = 26;
  // x^26 tap (bit 25) plus bit 5
  localparam logic [63:0] DEFAULT_TAP_MASK = 64'h0000_0000_0200_0020;
  localparam logic [63:0] DEFAULT_SEED     = 64'h0000_0000_0000_0001;

endpackage

// File: rtl/lfsr_core.sv
// LFSR state register with feedback and mode-dependent next state.
// Optional all-zero recovery when LFSR_SCRAMBLER_LOCKUP_DETECT_EN is defined.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] TAP_MASK     = WIDTH'(DEFAULT_TAP_MASK),
  parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(DEFAULT_SEED)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       i_mode,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_seed,
  input  logic             i_shift,
  input  logic             i_in_data,
  output logic             o_out_bit,
  output logic             o_lockup
);

  logic [WIDTH-1:0] r_state;
  logic             w_fb;
  logic             w_scr_bit;
  logic             w_shift_in;
  logic [WIDTH-1:0] w_next;

  assign w_fb      = ^(r_state & TAP_MASK);
  assign w_scr_bit = i_in_data ^ w_fb;
  assign o_out_bit = (i_mode == GEN) ? w_fb : w_scr_bit;

  // Descrambler shifts in the received bit so it tracks the scrambler state
  always_comb begin
    w_shift_in = w_fb;
    case (i_mode)
      GEN:     w_shift_in = w_fb;
      SCR:     w_shift_in = w_scr_bit;
      DSCR:    w_shift_in = i_in_data;
      default: w_shift_in = w_fb;
    endcase
  end

  assign w_next = {r_state[WIDTH-2:0], w_shift_in};

`ifdef LFSR_SCRAMBLER_LOCKUP_DETECT_EN
  logic r_lockup;
  logic w_zero_trap;

  assign w_zero_trap = (r_state == '0) && ((i_mode == GEN) || (i_mode == SCR));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= SEED_DEFAULT;
      r_lockup <= 1'b0;
    end else if (i_load) begin
      r_state  <= i_seed;
      r_lockup <= 1'b0;
    end else if (w_zero_trap) begin
      r_state  <= SEED_DEFAULT;
      r_lockup <= 1'b1;
    end else if (i_shift) begin
      r_state  <= w_next;
    end
  end

  assign o_lockup = r_lockup;
`else
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= SEED_DEFAULT;
    end else if (i_load) begin
      r_state <= i_seed;
    end else if (i_shift) begin
      r_state <= w_next;
    end
  end

  assign o_lockup = 1'b0;
`endif

endmodule

// File: rtl/lfsr_scrambler.sv
// Bit-serial LFSR generator/scrambler/descrambler with valid/ready handshake.
// Build option: LFSR_SCRAMBLER_LOCKUP_DETECT_EN enables all-zero lockup recovery.
module lfsr_scrambler
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] TAP_MASK     = WIDTH'(DEFAULT_TAP_MASK),
  parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(DEFAULT_SEED)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             in_valid,
  input  logic             in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic             out_data,
  input  logic             out_ready,
  output logic [31:0]      bit_count,
  output logic             lockup
);

  logic        r_out_valid;
  logic        r_out_data;
  logic [31:0] r_bit_count;
  logic        w_in_ready;
  logic        w_xfer;
  logic        w_out_bit;

  assign w_in_ready = (~r_out_valid | out_ready) & (mode != RSVD);
  assign w_xfer     = in_valid & w_in_ready & ~load;

  lfsr_core #(
    .WIDTH        (WIDTH),
    .TAP_MASK     (TAP_MASK),
    .SEED_DEFAULT (SEED_DEFAULT)
  ) u_core (
    .clock     (clock),
    .reset     (reset),
    .i_mode    (mode),
    .i_load    (load),
    .i_seed    (seed),
    .i_shift   (w_xfer),
    .i_in_data (in_data),
    .o_out_bit (w_out_bit),
    .o_lockup  (lockup)
  );

  // Load wins over a coincident transfer; the count saturates rather than wraps
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= 1'b0;
      r_bit_count <= 32'd0;
    end else if (load) begin
      r_out_valid <= 1'b0;
      r_bit_count <= 32'd0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_out_bit;
      if (r_bit_count != 32'hFFFF_FFFF) begin
        r_bit_count <= r_bit_count + 32'd1;
      end
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign bit_count = r_bit_count;

endmodule

// File: tb/tb_lfsr_scrambler.sv
// Randomized self-checking bench for lfsr_scrambler against a bit-level reference model.
module tb_lfsr_scrambler;

  localparam int         W     = 4;
  localparam logic [3:0] TAP   = 4'b1001;
  localparam logic [3:0] SEED0 = 4'b0001;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, load, in_valid, in_data, out_ready;
  logic [1:0]  mode;
  logic [3:0]  seed;
  logic        in_ready, out_valid, out_data, lockup;
  logic [31:0] bit_count;

  lfsr_scrambler #(.WIDTH(W), .TAP_MASK(TAP), .SEED_DEFAULT(SEED0)) dut (
    .clock(clock), .reset(reset), .mode(mode), .load(load), .seed(seed),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .bit_count(bit_count), .lockup(lockup)
  );

  // Scrambler feeding descrambler
  logic        rst2, c_in_data;
  logic        s_ready, s_valid, s_data, s_lock, d_ready, d_valid, d_data, d_lock;
  logic [31:0] s_cnt, d_cnt;

  lfsr_scrambler #(.WIDTH(W), .TAP_MASK(TAP), .SEED_DEFAULT(SEED0)) u_scr (
    .clock(clock), .reset(rst2), .mode(2'b01), .load(1'b0), .seed(4'h0),
    .in_valid(1'b1), .in_data(c_in_data), .in_ready(s_ready),
    .out_valid(s_valid), .out_data(s_data), .out_ready(d_ready),
    .bit_count(s_cnt), .lockup(s_lock)
  );

  lfsr_scrambler #(.WIDTH(W), .TAP_MASK(TAP), .SEED_DEFAULT(SEED0)) u_dscr (
    .clock(clock), .reset(rst2), .mode(2'b10), .load(1'b0), .seed(4'h0),
    .in_valid(s_valid), .in_data(s_data), .in_ready(d_ready),
    .out_valid(d_valid), .out_data(d_data), .out_ready(1'b1),
    .bit_count(d_cnt), .lockup(d_lock)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model
  logic [3:0]  m_state;
  logic        m_ov, m_od, m_lock;
  logic [31:0] m_cnt;

  task automatic model_reset();
    m_state = SEED0; m_ov = 1'b0; m_od = 1'b0; m_cnt = 32'd0; m_lock = 1'b0;
  endtask

  // Apply the current inputs for one clock edge and compare every output afterwards
  task automatic step();
    logic        exp_rdy, xfer, f, b, ins, n_ov, n_od, n_lock;
    logic [3:0]  n_state;
    logic [31:0] n_cnt;
    #1;
    exp_rdy = (!m_ov || out_ready) && (mode != 2'b11);
    chk("in_ready", in_ready, exp_rdy);
    xfer = in_valid && exp_rdy && !load;
    n_state = m_state; n_ov = m_ov; n_od = m_od; n_cnt = m_cnt; n_lock = m_lock;
    if (load) begin
      n_state = seed; n_ov = 1'b0; n_cnt = 32'd0; n_lock = 1'b0;
    end else begin
      if (xfer) begin
        f       = 1'($countones(m_state & TAP) % 2);
        b       = (mode == 2'd0) ? f : (in_data ^ f);
        ins     = (mode == 2'd2) ? in_data : b;
        n_state = 4'((m_state * 2 + ins) % 16);
        n_od    = b;
        n_ov    = 1'b1;
        n_cnt   = (m_cnt == 32'hFFFF_FFFF) ? m_cnt : m_cnt + 1;
      end else if (out_ready) begin
        n_ov = 1'b0;
      end
`ifdef LFSR_SCRAMBLER_LOCKUP_DETECT_EN
      if (m_state == 4'd0 && mode < 2'd2) begin
        n_state = SEED0; n_lock = 1'b1;
      end
`endif
    end
    @(posedge clock);
    #1;
    m_state = n_state; m_ov = n_ov; m_od = n_od; m_cnt = n_cnt; m_lock = n_lock;
    chk("out_valid", out_valid, m_ov);
    if (m_ov) chk("out_data", out_data, m_od);
    chk("bit_count", bit_count, m_cnt);
    chk("lockup", lockup, m_lock);
    chk("state", dut.u_core.r_state, m_state);
  endtask

  initial begin
    logic [3:0] first4;
    logic       hold_d;
    logic       exp_bit;
    int         n_out;
    logic       q[$];

    reset = 1'b1; rst2 = 1'b1; load = 1'b0; seed = 4'h0; mode = 2'b00;
    in_valid = 1'b0; in_data = 1'b0; out_ready = 1'b0; c_in_data = 1'b0;
    #1;
    model_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_bit_count", bit_count, 0);
    chk("rst_lockup", lockup, 0);
    chk("rst_state", dut.u_core.r_state, 4'b0001);
    @(negedge clock);
    reset = 1'b0;

    // GEN from seed 1: full period of 15
    mode = 2'b00; in_valid = 1'b1; out_ready = 1'b1;
    first4 = 4'h0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (i < 4) first4[3-i] = out_data;
    end
    chk("gen_first4", first4, 4'b1110);
    chk("gen_period_state", dut.u_core.r_state, 4'b0001);
    chk("gen_period_count", bit_count, 15);

    // Backpressure holds everything
    out_ready = 1'b0;
    hold_d = out_data;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_data", out_data, hold_d);
      chk("stall_count", bit_count, 15);
      chk("stall_state", dut.u_core.r_state, 4'b0001);
    end

    // Load beats a coincident transfer
    out_ready = 1'b1; load = 1'b1; seed = 4'b0110; in_valid = 1'b1;
    step();
    load = 1'b0;
    chk("load_state", dut.u_core.r_state, 4'b0110);
    chk("load_out_valid", out_valid, 0);
    chk("load_count", bit_count, 0);

    for (int i = 0; i < 400; i++) begin
      mode      = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      load      = ($urandom_range(0, 39) == 0);
      seed      = 4'($urandom_range(1, 15));
      step();
    end
    load = 1'b0;

    // All-zero seed in GEN
    mode = 2'b00; out_ready = 1'b1; in_valid = 1'b0; load = 1'b1; seed = 4'h0;
    step();
    load = 1'b0;
    step();
`ifdef LFSR_SCRAMBLER_LOCKUP_DETECT_EN
    chk("lock_state", dut.u_core.r_state, SEED0);
    chk("lock_flag", lockup, 1);
`else
    chk("zero_state", dut.u_core.r_state, 4'h0);
    chk("zero_flag", lockup, 0);
`endif
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
`ifndef LFSR_SCRAMBLER_LOCKUP_DETECT_EN
      chk("zero_out", out_data, 0);
`endif
    end

    // Asynchronous reset mid-stream
    load = 1'b1; seed = 4'b1011;
    step();
    load = 1'b0;
    for (int i = 0; i < 3; i++) step();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("arst_out_valid", out_valid, 0);
    chk("arst_count", bit_count, 0);
    chk("arst_state", dut.u_core.r_state, SEED0);
    chk("arst_lockup", lockup, 0);
    @(posedge clock);
    #1;
    chk("arst_hold_valid", out_valid, 0);
    @(negedge clock);
    reset = 1'b0;
    step();
    chk("arst_first_bit", out_data, 1);
    step();
    chk("arst_second_bit", out_data, 1);

    // Scrambler -> descrambler loopback
    @(negedge clock);
    rst2 = 1'b0;
    n_out = 0;
    for (int i = 0; i < 1000; i++) begin
      c_in_data = 1'($urandom);
      @(posedge clock);
      q.push_back(c_in_data);
      #1;
      if (d_valid) begin
        exp_bit = q.pop_front();
        chk("loop_bit", d_data, exp_bit);
        n_out++;
      end
    end
    chk("loop_outputs", n_out, 999);
    chk("loop_scr_count", s_cnt, 1000);
    chk("loop_dscr_count", d_cnt, 999);
    chk("loop_ready", s_ready & d_ready, 1);
    chk("loop_lock", s_lock | d_lock, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
